regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (RegWrite/AdInReg/DInReg) among three requesters: core writeback (highest priority), TRIGGER event (writes 1 to t0), and a host/debug write port with valid/ready handshake buffered in a small FIFO.
- Sits between the writeback stage and the register file.
- Bounds host/trigger starvation by asserting a one-cycle pipeline Stall.

---
 rtl/regfile_arb_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_wr_fifo.sv | 69 ++++++
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   gnt_e      : which requester owns the write port this cycle
//   host_req_t : one buffered host write (address + data) at default widths
//   TRIG_AD_T0 : register written by a trigger event (t0)
package regfile_arb_pkg;

  localparam int unsigned ARB_WAD    = 5;
  localparam int unsigned ARB_WD     = 32;
  localparam int unsigned TRIG_AD_T0 = 5;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_TRIG = 2'd2,
    GNT_HOST = 2'd3
  } gnt_e;

  typedef struct packed {
    logic [ARB_WAD-1:0] ad;
    logic [ARB_WD-1:0]  data;
  } host_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle around the register-file write arbiter.
//   master : writeback stage / trigger source / host side (drives requests)
//   slave  : the arbiter (drives the register-file write port and status)
// Signals: WbRegWrite/WbAd/WbData, TRIGGER, HostValid/HostReady/HostAd/HostData,
//          Stall, RegWrite/AdInReg/DInReg, HostLevel, TrigPending.
interface regfile_write_arbiter_if #(
  parameter int unsigned WAD   = 5,
  parameter int unsigned WD    = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic           WbRegWrite;
  logic [WAD-1:0] WbAd;
  logic [WD-1:0]  WbData;
  logic           TRIGGER;
  logic           HostValid;
  logic           HostReady;
  logic [WAD-1:0] HostAd;
  logic [WD-1:0]  HostData;
  logic           Stall;
  logic           RegWrite;
  logic [WAD-1:0] AdInReg;
  logic [WD-1:0]  DInReg;
  logic [LW-1:0]  HostLevel;
  logic           TrigPending;

  modport master (
    output WbRegWrite, WbAd, WbData, TRIGGER, HostValid, HostAd, HostData,
    input  HostReady, Stall, RegWrite, AdInReg, DInReg, HostLevel, TrigPending
  );

  modport slave (
    input  WbRegWrite, WbAd, WbData, TRIGGER, HostValid, HostAd, HostData,
    output HostReady, Stall, RegWrite, AdInReg, DInReg, HostLevel, TrigPending
  );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO buffering host register writes.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : enqueue (ignored when full)
//   pop, dout  : dequeue (ignored when empty); dout shows the head entry
//   full, empty, level : occupancy status
module regfile_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/storage update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among core writeback (highest
// priority), trigger events (write 1 to t0) and a FIFO-buffered host port.
// A starve counter forces a one-cycle pipeline Stall so pending trigger/host
// writes cannot wait forever behind back-to-back core writes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_write_arbiter_if (requests in,
//              RegWrite/AdInReg/DInReg, HostReady, Stall, HostLevel, TrigPending out)
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned WAD        = ARB_WAD,
  parameter int unsigned WD         = ARB_WD,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_STARVE = 8,
  parameter int unsigned TRIG_AD    = TRIG_AD_T0
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = WAD + WD;
  localparam int unsigned CW = $clog2(MAX_STARVE + 1);

  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LW-1:0]  fifo_level;
  logic [PW-1:0]  fifo_dout;
  logic           host_ready_c;

  gnt_e           gnt_c;
  logic [WAD-1:0] wr_ad_c;
  logic [WD-1:0]  wr_data_c;
  logic           pending_c, nc_gnt_c;

  logic           trig_pend_q, trig_pend_d;
  logic [CW-1:0]  starve_q, starve_d;
  logic           stall_q, stall_d;

  // Ready depends only on registered occupancy and reset, never on HostValid
  assign host_ready_c = !fifo_full && !rst;
  assign fifo_push    = bus.HostValid && host_ready_c;
  assign fifo_pop     = (gnt_c == GNT_HOST);

  regfile_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.HostAd, bus.HostData}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Grant selection: core unless stalled, then trigger, then host FIFO head
  always_comb begin
    gnt_c     = GNT_NONE;
    wr_ad_c   = '0;
    wr_data_c = '0;
    if (!rst) begin
      if (bus.WbRegWrite && !stall_q) begin
        gnt_c = GNT_CORE;
      end else if (trig_pend_q) begin
        gnt_c = GNT_TRIG;
      end else if (!fifo_empty) begin
        gnt_c = GNT_HOST;
      end
    end
    case (gnt_c)
      GNT_CORE: begin
        wr_ad_c   = bus.WbAd;
        wr_data_c = bus.WbData;
      end
      GNT_TRIG: begin
        wr_ad_c   = WAD'(TRIG_AD);
        wr_data_c = WD'(1);
      end
      GNT_HOST: begin
        wr_ad_c   = fifo_dout[PW-1:WD];
        wr_data_c = fifo_dout[WD-1:0];
      end
      default: ;
    endcase
  end

  // Trigger latch and starve counter next state
  always_comb begin
    pending_c   = trig_pend_q || !fifo_empty;
    nc_gnt_c    = (gnt_c == GNT_TRIG) || (gnt_c == GNT_HOST);
    trig_pend_d = bus.TRIGGER || (trig_pend_q && (gnt_c != GNT_TRIG));
    starve_d    = starve_q;
    if (!pending_c || nc_gnt_c) begin
      starve_d = '0;
    end else if (starve_q < CW'(MAX_STARVE)) begin
      starve_d = starve_q + CW'(1);
    end
    // Stall the cycle after the counter hits its limit; the forced grant then clears it
    stall_d = (starve_d == CW'(MAX_STARVE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_pend_q <= 1'b0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
    end else begin
      trig_pend_q <= trig_pend_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
    end
  end

  // Writes to x0 are consumed but never reach the register file
  assign bus.RegWrite    = (gnt_c != GNT_NONE) && (wr_ad_c != '0);
  assign bus.AdInReg     = wr_ad_c;
  assign bus.DInReg      = wr_data_c;
  assign bus.HostReady   = host_ready_c;
  // Status is held at its reset value while rst is asserted
  assign bus.Stall       = stall_q && !rst;
  assign bus.TrigPending = trig_pend_q && !rst;
  assign bus.HostLevel   = rst ? '0 : fifo_level;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, a
// starvation sequence, then random traffic against a queue-based model.
module tb_regfile_write_arbiter
  import regfile_arb_pkg::*;
;
  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;
  localparam int N_RAND     = 400;

  typedef struct packed {
    logic        rst;
    logic        wb;
    logic [4:0]  wbad;
    logic [31:0] wbd;
    logic        trig;
    logic        hv;
    logic [4:0]  had;
    logic [31:0] hd;
  } in_t;

  typedef struct packed {
    logic        ready;
    logic        rw;
    logic [4:0]  ad;
    logic [31:0] din;
    logic        stall;
    logic [2:0]  lvl;
    logic        tp;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  host_req_t m_q[$];
  bit        m_trig;
  bit        m_stall;
  int        m_starve;

  regfile_write_arbiter_if #(.WAD(5), .WD(32), .DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .WAD(5), .WD(32), .DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE), .TRIG_AD(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  task automatic chk_out(input string tag, input out_t a, input out_t e);
    chk({tag, " HostReady"},   32'(a.ready), 32'(e.ready));
    chk({tag, " RegWrite"},    32'(a.rw),    32'(e.rw));
    chk({tag, " AdInReg"},     32'(a.ad),    32'(e.ad));
    chk({tag, " DInReg"},      a.din,        e.din);
    chk({tag, " Stall"},       32'(a.stall), 32'(e.stall));
    chk({tag, " HostLevel"},   32'(a.lvl),   32'(e.lvl));
    chk({tag, " TrigPending"}, 32'(a.tp),    32'(e.tp));
  endtask

  function automatic vec_t mk(
    input int unsigned r, wb, wa, wd, tg, hv, ha, hd,
    input int unsigned ery, erw, ead, ed, est, elv, etp);
    vec_t v;
    v.i.rst  = 1'(r);   v.i.wb = 1'(wb); v.i.wbad = 5'(wa); v.i.wbd = wd;
    v.i.trig = 1'(tg);  v.i.hv = 1'(hv); v.i.had  = 5'(ha); v.i.hd  = hd;
    v.o.ready = 1'(ery); v.o.rw = 1'(erw); v.o.ad = 5'(ead); v.o.din = ed;
    v.o.stall = 1'(est); v.o.lvl = 3'(elv); v.o.tp = 1'(etp);
    return v;
  endfunction

  // Behavioural model: priority pick, queue for the FIFO, integer starve count
  task automatic model_step(input in_t in, output out_t e);
    gnt_e      g;
    host_req_t h;
    bit        was_pending;
    e = '0;
    if (in.rst) begin
      m_q.delete();
      m_trig   = 0;
      m_stall  = 0;
      m_starve = 0;
      return;
    end
    was_pending = m_trig || (m_q.size() != 0);
    e.ready = (m_q.size() < DEPTH);
    e.stall = m_stall;
    e.lvl   = 3'(m_q.size());
    e.tp    = m_trig;
    if (in.wb && !m_stall)    g = GNT_CORE;
    else if (m_trig)          g = GNT_TRIG;
    else if (m_q.size() != 0) g = GNT_HOST;
    else                      g = GNT_NONE;
    case (g)
      GNT_CORE: begin e.ad = in.wbad; e.din = in.wbd; end
      GNT_TRIG: begin e.ad = 5'd5;    e.din = 32'd1;  end
      GNT_HOST: begin h = m_q.pop_front(); e.ad = h.ad; e.din = h.data; end
      default: ;
    endcase
    e.rw = (g != GNT_NONE) && (e.ad != 5'd0);
    if (in.hv && e.ready) begin
      h.ad   = in.had;
      h.data = in.hd;
      m_q.push_back(h);
    end
    m_trig = in.trig || (m_trig && g != GNT_TRIG);
    if (g == GNT_TRIG || g == GNT_HOST || !was_pending) m_starve = 0;
    else if (m_starve < MAX_STARVE)                     m_starve = m_starve + 1;
    m_stall = (m_starve == MAX_STARVE);
  endtask

  task automatic drive(input in_t in);
    rst            = in.rst;
    bus.WbRegWrite = in.wb;
    bus.WbAd       = in.wbad;
    bus.WbData     = in.wbd;
    bus.TRIGGER    = in.trig;
    bus.HostValid  = in.hv;
    bus.HostAd     = in.had;
    bus.HostData   = in.hd;
  endtask

  function automatic out_t sample();
    out_t a;
    a.ready = bus.HostReady;
    a.rw    = bus.RegWrite;
    a.ad    = bus.AdInReg;
    a.din   = bus.DInReg;
    a.stall = bus.Stall;
    a.lvl   = bus.HostLevel;
    a.tp    = bus.TrigPending;
    return a;
  endfunction

  // One clock: drive, sample mid-cycle, advance model, step past the edge
  task automatic run_cycle(input in_t in, output out_t act, output out_t exp);
    drive(in);
    @(negedge clk);
    act = sample();
    model_step(in, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[$];
    in_t  in;
    out_t act, exp;

    //          rst wb wad wbd     tg hv had hd       rdy rw ad din     st lv tp
    vt.push_back(mk(1, 0, 0,  0,      0, 1, 3,  'h77,   0, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(1, 0, 0,  0,      0, 1, 3,  'h77,   0, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 1, 11, 'hAB,   1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 1, 10, 'h1234, 0, 0, 0,  0,      1, 1, 10, 'h1234, 0, 1, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 11, 'hAB,   0, 1, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      1, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 5,  1,      0, 0, 1));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      1, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      1, 0, 0,  0,      1, 1, 5,  1,      0, 0, 1));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 5,  1,      0, 0, 1));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 1, 1,  'h100,  0, 1, 12, 'hC0,   1, 1, 1,  'h100,  0, 0, 0));
    vt.push_back(mk(0, 1, 1,  'h101,  0, 1, 13, 'hC1,   1, 1, 1,  'h101,  0, 1, 0));
    vt.push_back(mk(0, 1, 1,  'h102,  0, 1, 14, 'hC2,   1, 1, 1,  'h102,  0, 2, 0));
    vt.push_back(mk(0, 1, 1,  'h103,  0, 1, 15, 'hC3,   1, 1, 1,  'h103,  0, 3, 0));
    vt.push_back(mk(0, 1, 1,  'h104,  0, 1, 16, 'hC4,   0, 1, 1,  'h104,  0, 4, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 1, 16, 'hC4,   0, 1, 12, 'hC0,   0, 4, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 1, 16, 'hC4,   1, 1, 13, 'hC1,   0, 3, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 14, 'hC2,   0, 3, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 15, 'hC3,   0, 2, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 1, 16, 'hC4,   0, 1, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 1, 0,  'h55,   1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  'h55,   0, 1, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 1, 0,  'h99,   0, 0, 0,  0,      1, 0, 0,  'h99,   0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      1, 1, 7,  'h1,    1, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(1, 0, 0,  0,      0, 0, 0,  0,      0, 0, 0,  0,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0,      0, 0, 0,  0,      1, 0, 0,  0,      0, 0, 0));

    foreach (vt[k]) begin
      run_cycle(vt[k].i, act, exp);
      chk_out($sformatf("vec%0d", k), act, vt[k].o);
    end

    // Starvation: host entry queued behind continuous core writes
    for (int i = 0; i <= 10; i++) begin
      in      = '0;
      in.wb   = 1'b1;
      in.wbad = 5'd2;
      in.wbd  = 32'h5000 + 32'(i);
      if (i == 0) begin
        in.hv  = 1'b1;
        in.had = 5'd20;
        in.hd  = 32'hEE;
      end
      run_cycle(in, act, exp);
      chk($sformatf("starve%0d Stall", i), 32'(act.stall), (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d AdInReg", i), 32'(act.ad), (i == 9) ? 32'd20 : 32'd2);
      chk($sformatf("starve%0d RegWrite", i), 32'(act.rw), 32'd1);
      if (i == 9) begin
        chk("starve9 DInReg", act.din, 32'hEE);
        chk("starve9 HostLevel", 32'(act.lvl), 32'd1);
      end
      if (i == 10) chk("starve10 HostLevel", 32'(act.lvl), 32'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < N_RAND; n++) begin
      in.rst  = ($urandom_range(0, 99) < 2);
      in.wb   = ($urandom_range(0, 99) < 75);
      in.wbad = 5'($urandom);
      in.wbd  = $urandom;
      in.trig = ($urandom_range(0, 99) < 8);
      in.hv   = ($urandom_range(0, 99) < 45);
      in.had  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in.hd   = $urandom;
      run_cycle(in, act, exp);
      chk_out($sformatf("rand%0d", n), act, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
